// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard/stall controller: FSM state, register index width,
// and the packed pipeline-control word that selects enables and NOP loads.
package hazard_stall_controller_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // MSB..LSB: PC, IF/ID, ID/EX, EX/MEM enables, then IF/ID, ID/EX, MEM/WB NOP loads
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE  = 7'b1111_000;
  localparam ctrl_t CTRL_FREEZE   = 7'b0000_001;
  localparam ctrl_t CTRL_RESET    = 7'b0000_111;
  localparam ctrl_t CTRL_BRANCH   = 7'b1111_110;
  localparam ctrl_t CTRL_LOAD_USE = 7'b0011_010;

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a
// load currently in EX (x0 never creates a dependency).
module hazard_stall_controller_hazard_detect
  import hazard_stall_controller_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  input  logic [REG_IDX_W-1:0] rd_ID_EX,
  input  logic                 memRead_ID_EX,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = use_rs1_ID && (rd_ID_EX == rs1_ID);
  assign rs2_hit  = use_rs2_ID && (rd_ID_EX == rs2_ID);
  assign load_use = memRead_ID_EX && (rd_ID_EX != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use bubble, branch flush, and data-memory
// freeze with bounded wait. Optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  input  logic [REG_IDX_W-1:0] rd_ID_EX,
  input  logic                 memRead_ID_EX,
  input  logic                 branch_taken_EX,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events,
`endif
  output logic                 PC_WE,
  output logic                 IF_ID_WE,
  output logic                 ID_EX_WE,
  output logic                 EX_MEM_WE,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_flush,
  output logic                 MEM_WB_flush,
  output logic                 mem_timeout
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_use;
  ctrl_t            pipe_ctrl;
  ctrl_t            ctrl;
  logic             timeout_next;
  logic             freeze_cyc;
  logic             lu_stall_cyc;
  logic             branch_cyc;

  hazard_stall_controller_hazard_detect u_hazard_detect (
    .rs1_ID        (rs1_ID),
    .rs2_ID        (rs2_ID),
    .use_rs1_ID    (use_rs1_ID),
    .use_rs2_ID    (use_rs2_ID),
    .rd_ID_EX      (rd_ID_EX),
    .memRead_ID_EX (memRead_ID_EX),
    .load_use      (load_use)
  );

  // Branch outranks load-use: the dependent ID instruction is being discarded.
  always_comb begin
    pipe_ctrl = CTRL_ADVANCE;
    if (branch_taken_EX)
      pipe_ctrl = CTRL_BRANCH;
    else if (load_use)
      pipe_ctrl = CTRL_LOAD_USE;
  end

  always_comb begin
    ctrl         = pipe_ctrl;
    timeout_next = 1'b0;
    freeze_cyc   = 1'b0;
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze_cyc = 1'b1;
          state_next = MEM_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = RUN;
          cnt_next   = '0;
        end else if (cnt_reg < CNT_W'(MEM_TIMEOUT)) begin
          freeze_cyc = 1'b1;
          cnt_next   = cnt_reg + CNT_W'(1);
        end else begin
          timeout_next = 1'b1;
          state_next   = RUN;
          cnt_next     = '0;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    if (freeze_cyc)
      ctrl = CTRL_FREEZE;
    if (rst) begin
      ctrl         = CTRL_RESET;
      timeout_next = 1'b0;
      freeze_cyc   = 1'b0;
      state_next   = RUN;
      cnt_next     = '0;
    end
  end

  assign lu_stall_cyc = !rst && !freeze_cyc && !branch_taken_EX && load_use;
  assign branch_cyc   = !rst && !freeze_cyc && branch_taken_EX;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_events_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (freeze_cyc || lu_stall_cyc)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (branch_cyc)
        flush_events_reg <= flush_events_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`endif

  assign PC_WE        = ctrl.pc_we;
  assign IF_ID_WE     = ctrl.if_id_we;
  assign ID_EX_WE     = ctrl.id_ex_we;
  assign EX_MEM_WE    = ctrl.ex_mem_we;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign MEM_WB_flush = ctrl.mem_wb_flush;
  assign mem_timeout  = timeout_next;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios then random
// traffic, compared each cycle against a behavioural model of the pipeline rules.
module tb_hazard_stall_controller;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_ID_EX;
  logic       use_rs1_ID, use_rs2_ID, memRead_ID_EX, branch_taken_EX;
  logic       dmem_req, dmem_ready;
  logic       PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE;
  logic       IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: are we waiting on memory, and for how many cycles so far
  bit          m_waiting = 1'b0;
  int          m_waited  = 0;
  int unsigned m_stalls  = 0;
  int unsigned m_flushes = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .use_rs1_ID      (use_rs1_ID),
    .use_rs2_ID      (use_rs2_ID),
    .rd_ID_EX        (rd_ID_EX),
    .memRead_ID_EX   (memRead_ID_EX),
    .branch_taken_EX (branch_taken_EX),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
`endif
    .PC_WE           (PC_WE),
    .IF_ID_WE        (IF_ID_WE),
    .ID_EX_WE        (ID_EX_WE),
    .EX_MEM_WE       (EX_MEM_WE),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .MEM_WB_flush    (MEM_WB_flush),
    .mem_timeout     (mem_timeout)
  );

  task automatic drive(input bit r, input int s1, input int s2, input bit u1, input bit u2,
                       input int rd, input bit mr, input bit br, input bit rq, input bit rdy);
    rst = r; rs1_ID = 5'(s1); rs2_ID = 5'(s2); use_rs1_ID = u1; use_rs2_ID = u2;
    rd_ID_EX = 5'(rd); memRead_ID_EX = mr; branch_taken_EX = br;
    dmem_req = rq; dmem_ready = rdy;
  endtask

  // One cycle: check at negedge against the model, then advance the model at posedge.
  task automatic cycle(input string tag);
    bit         lu, frozen, forced;
    logic [7:0] exp_v, obs_v;
    @(negedge clk);
    lu = memRead_ID_EX && rd_ID_EX != 0 &&
         ((use_rs1_ID && rd_ID_EX == rs1_ID) || (use_rs2_ID && rd_ID_EX == rs2_ID));
    frozen = !rst && ((!m_waiting && dmem_req && !dmem_ready) ||
                      (m_waiting && !dmem_ready && m_waited < T));
    forced = !rst && m_waiting && !dmem_ready && m_waited >= T;
    // bits: PC_WE IF_ID_WE ID_EX_WE EX_MEM_WE IF_ID_flush ID_EX_flush MEM_WB_flush mem_timeout
    if (rst)                  exp_v = 8'b0000_1110;
    else if (frozen)          exp_v = 8'b0000_0010;
    else if (branch_taken_EX) exp_v = {7'b1111_110, forced};
    else if (lu)              exp_v = {7'b0011_010, forced};
    else                      exp_v = {7'b1111_000, forced};
    obs_v = {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fails++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    assert (stall_cycles === m_stalls && flush_events === m_flushes) else begin
      n_fails++;
      $error("FAIL %s perf observed=%0d/%0d expected=%0d/%0d", tag, stall_cycles, flush_events,
             m_stalls, m_flushes);
    end
`endif
    @(posedge clk);
    if (rst) begin
      m_waiting = 1'b0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (frozen || (lu && !branch_taken_EX)) m_stalls++;
      if (!frozen && branch_taken_EX) m_flushes++;
      if (!m_waiting) begin
        if (dmem_req && !dmem_ready) begin m_waiting = 1'b1; m_waited = 1; end
      end else if (dmem_ready || m_waited >= T) begin
        m_waiting = 1'b0; m_waited = 0;
      end else begin
        m_waited++;
      end
    end
    #1;
    $display("cycle %-12s rst=%0b req=%0b rdy=%0b br=%0b lu=%0b -> ctrl=%b", tag, rst, dmem_req,
             dmem_ready, branch_taken_EX, lu, obs_v);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset0");
    cycle("reset1");
    // load-use on rs1, one bubble, then the load moves on
    drive(0, 5, 7, 1, 0, 5, 1, 0, 0, 0);  cycle("lu_rs1");
    drive(0, 5, 7, 1, 0, 9, 0, 0, 0, 0);  cycle("lu_after");
    drive(0, 3, 6, 0, 1, 6, 1, 0, 0, 0);  cycle("lu_rs2");
    drive(0, 0, 7, 1, 0, 0, 1, 0, 0, 0);  cycle("lu_x0");
    drive(0, 5, 7, 0, 0, 5, 1, 0, 0, 0);  cycle("lu_nouse");
    drive(0, 5, 7, 1, 0, 5, 1, 1, 0, 0);  cycle("br_over_lu");
    drive(0, 1, 2, 1, 1, 3, 0, 0, 1, 1);  cycle("single_acc");
    // three frozen cycles, release on the fourth with a pending branch
    drive(0, 1, 2, 1, 1, 3, 0, 1, 1, 0);  cycle("freeze1");
    cycle("freeze2");
    cycle("freeze3");
    drive(0, 1, 2, 1, 1, 3, 0, 1, 1, 1);  cycle("release");
    drive(0, 1, 2, 1, 1, 3, 0, 0, 0, 0);  cycle("advance");
    // ready held low: forced release on the 4th MEM_WAIT cycle
    drive(0, 1, 2, 1, 1, 3, 0, 0, 1, 0);
    for (int i = 0; i < T + 1; i++) cycle("timeout_seq");
    drive(0, 1, 2, 1, 1, 3, 0, 0, 0, 0);  cycle("post_to");
    // reset in the middle of a memory wait
    drive(0, 1, 2, 1, 1, 3, 0, 0, 1, 0);  cycle("pre_rst1");
    cycle("pre_rst2");
    drive(1, 1, 2, 1, 1, 3, 0, 0, 1, 0);  cycle("mid_rst");
    drive(0, 1, 2, 1, 1, 3, 0, 0, 0, 0);  cycle("after_rst");
    // random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      cycle("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
